// File: rtl/lc4_dmem_arbiter.sv
// lc4_dmem_arbiter
// Shares the single data-memory port of lc4_memory between the processor
// data path (P) and an auxiliary agent (A). A request is accepted only in a
// dre slot while the FSM is idle. Each transaction then runs through
// ISSUE -> (RD_WAIT) -> RESP. When both requesters are valid, the one not
// granted last wins.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   dre                       data-memory access slot strobe
//   {p,a}_req_valid/ready     request handshake (ready is combinational)
//   {p,a}_req_we/addr/wdata   request payload
//   {p,a}_rsp_valid/data      one-cycle response pulse and read data
//   mem_raddr/waddr/din/we    drive lc4_memory draddr/dwaddr/din/dwe
//   mem_dout                  read data from lc4_memory
//   busy                      a transaction is in flight
//   grant_a                   owner of the current/last transaction (1 = A)
//
// Optional build macro LC4_DMEM_ARB_STATS_EN adds saturating 32-bit
// counters stat_p_grants, stat_a_grants and stat_conflicts.
module lc4_dmem_arbiter #(
  parameter int WORD_SIZE  = 256,
  parameter int ADDR_BITS  = 5,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dre,
  input  logic                 p_req_valid,
  output logic                 p_req_ready,
  input  logic                 p_req_we,
  input  logic [ADDR_BITS-1:0] p_req_addr,
  input  logic [WORD_SIZE-1:0] p_req_wdata,
  output logic                 p_rsp_valid,
  output logic [WORD_SIZE-1:0] p_rsp_data,
  input  logic                 a_req_valid,
  output logic                 a_req_ready,
  input  logic                 a_req_we,
  input  logic [ADDR_BITS-1:0] a_req_addr,
  input  logic [WORD_SIZE-1:0] a_req_wdata,
  output logic                 a_rsp_valid,
  output logic [WORD_SIZE-1:0] a_rsp_data,
  output logic [ADDR_BITS-1:0] mem_raddr,
  output logic [ADDR_BITS-1:0] mem_waddr,
  output logic [WORD_SIZE-1:0] mem_din,
  output logic                 mem_we,
  input  logic [WORD_SIZE-1:0] mem_dout,
  output logic                 busy,
  output logic                 grant_a
`ifdef LC4_DMEM_ARB_STATS_EN
  ,
  output logic [31:0]          stat_p_grants,
  output logic [31:0]          stat_a_grants,
  output logic [31:0]          stat_conflicts
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RD_WAIT, S_RESP} state_e;

  // RD_WAIT runs RD_LATENCY cycles; the counter starts one below that.
  localparam logic [1:0] RD_WAIT_INIT = 2'(RD_LATENCY - 1);

  state_e                 state_q, state_d;
  logic                   prio_a_q, prio_a_d;   // 1: A wins a tie
  logic                   owner_a_q, owner_a_d;
  logic                   we_q, we_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   mem_raddr_q, mem_raddr_d;
  logic [ADDR_BITS-1:0]   mem_waddr_q, mem_waddr_d;
  logic [WORD_SIZE-1:0]   mem_din_q, mem_din_d;
  logic                   mem_we_q, mem_we_d;
  logic                   p_rsp_valid_q, p_rsp_valid_d;
  logic                   a_rsp_valid_q, a_rsp_valid_d;
  logic [WORD_SIZE-1:0]   p_rsp_data_q, p_rsp_data_d;
  logic [WORD_SIZE-1:0]   a_rsp_data_q, a_rsp_data_d;

  logic win_a_s;
  logic slot_s;
  logic hs_s;

  // A wins if it is the only valid requester, or if both are valid and the
  // pointer favours A. Ready is gated by rst so nothing handshakes in reset.
  assign win_a_s     = a_req_valid & (~p_req_valid | prio_a_q);
  assign slot_s      = (state_q == S_IDLE) & dre & rst;
  assign p_req_ready = slot_s & p_req_valid & ~win_a_s;
  assign a_req_ready = slot_s & a_req_valid & win_a_s;
  assign hs_s        = p_req_ready | a_req_ready;

  assign mem_raddr   = mem_raddr_q;
  assign mem_waddr   = mem_waddr_q;
  assign mem_din     = mem_din_q;
  assign mem_we      = mem_we_q;
  assign p_rsp_valid = p_rsp_valid_q;
  assign a_rsp_valid = a_rsp_valid_q;
  assign p_rsp_data  = p_rsp_data_q;
  assign a_rsp_data  = a_rsp_data_q;
  assign busy        = (state_q != S_IDLE);
  assign grant_a     = owner_a_q;

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    state_d       = state_q;
    prio_a_d      = prio_a_q;
    owner_a_d     = owner_a_q;
    we_d          = we_q;
    cnt_d         = cnt_q;
    mem_raddr_d   = mem_raddr_q;
    mem_waddr_d   = mem_waddr_q;
    mem_din_d     = mem_din_q;
    mem_we_d      = 1'b0;
    p_rsp_valid_d = 1'b0;
    a_rsp_valid_d = 1'b0;
    p_rsp_data_d  = '0;
    a_rsp_data_d  = '0;
    case (state_q)
      S_IDLE: begin
        // The request payload is loaded straight into the memory-side
        // registers so the ISSUE cycle presents it with no extra stage.
        if (hs_s) begin
          owner_a_d   = win_a_s;
          prio_a_d    = ~win_a_s;
          we_d        = win_a_s ? a_req_we : p_req_we;
          mem_raddr_d = win_a_s ? a_req_addr : p_req_addr;
          mem_waddr_d = win_a_s ? a_req_addr : p_req_addr;
          mem_din_d   = win_a_s ? a_req_wdata : p_req_wdata;
          mem_we_d    = win_a_s ? a_req_we : p_req_we;
          state_d     = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          // Write response carries zero data (the default).
          p_rsp_valid_d = ~owner_a_q;
          a_rsp_valid_d = owner_a_q;
          state_d       = S_RESP;
        end else begin
          cnt_d   = RD_WAIT_INIT;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          p_rsp_valid_d = ~owner_a_q;
          a_rsp_valid_d = owner_a_q;
          p_rsp_data_d  = owner_a_q ? '0 : mem_dout;
          a_rsp_data_d  = owner_a_q ? mem_dout : '0;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      prio_a_q      <= 1'b0;
      owner_a_q     <= 1'b0;
      we_q          <= 1'b0;
      cnt_q         <= 2'd0;
      mem_raddr_q   <= '0;
      mem_waddr_q   <= '0;
      mem_din_q     <= '0;
      mem_we_q      <= 1'b0;
      p_rsp_valid_q <= 1'b0;
      a_rsp_valid_q <= 1'b0;
      p_rsp_data_q  <= '0;
      a_rsp_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      prio_a_q      <= prio_a_d;
      owner_a_q     <= owner_a_d;
      we_q          <= we_d;
      cnt_q         <= cnt_d;
      mem_raddr_q   <= mem_raddr_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_din_q     <= mem_din_d;
      mem_we_q      <= mem_we_d;
      p_rsp_valid_q <= p_rsp_valid_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      p_rsp_data_q  <= p_rsp_data_d;
      a_rsp_data_q  <= a_rsp_data_d;
    end
  end

`ifdef LC4_DMEM_ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
  endfunction

  logic        conflict_s;
  logic [31:0] stat_p_q, stat_a_q, stat_c_q;

  assign conflict_s     = (state_q == S_IDLE) & dre & p_req_valid & a_req_valid;
  assign stat_p_grants  = stat_p_q;
  assign stat_a_grants  = stat_a_q;
  assign stat_conflicts = stat_c_q;

  // Saturating grant and conflict counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_p_q <= 32'd0;
      stat_a_q <= 32'd0;
      stat_c_q <= 32'd0;
    end else begin
      stat_p_q <= sat_inc(stat_p_q, p_req_ready);
      stat_a_q <= sat_inc(stat_a_q, a_req_ready);
      stat_c_q <= sat_inc(stat_c_q, conflict_s);
    end
  end
`endif

endmodule

// File: tb/tb_lc4_dmem_arbiter.sv
// Directed self-checking bench for lc4_dmem_arbiter, with a behavioural
// lc4_memory (synchronous write, RDL-cycle registered read).
module tb_lc4_dmem_arbiter;

  localparam int RDL = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         dre = 1'b0;
  logic         p_req_valid = 1'b0, p_req_we = 1'b0;
  logic [4:0]   p_req_addr = 5'h00;
  logic [255:0] p_req_wdata = '0;
  logic         a_req_valid = 1'b0, a_req_we = 1'b0;
  logic [4:0]   a_req_addr = 5'h00;
  logic [255:0] a_req_wdata = '0;
  logic         p_req_ready, a_req_ready, p_rsp_valid, a_rsp_valid;
  logic [255:0] p_rsp_data, a_rsp_data, mem_din, mem_dout;
  logic [4:0]   mem_raddr, mem_waddr;
  logic         mem_we, busy, grant_a;
`ifdef LC4_DMEM_ARB_STATS_EN
  logic [31:0]  stat_p_grants, stat_a_grants, stat_conflicts;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  lc4_dmem_arbiter #(.WORD_SIZE(256), .ADDR_BITS(5), .RD_LATENCY(RDL)) dut (
    .clk(clk), .rst(rst), .dre(dre),
    .p_req_valid(p_req_valid), .p_req_ready(p_req_ready), .p_req_we(p_req_we),
    .p_req_addr(p_req_addr), .p_req_wdata(p_req_wdata),
    .p_rsp_valid(p_rsp_valid), .p_rsp_data(p_rsp_data),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout), .busy(busy), .grant_a(grant_a)
`ifdef LC4_DMEM_ARB_STATS_EN
    , .stat_p_grants(stat_p_grants), .stat_a_grants(stat_a_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural data memory.
  logic [255:0] mem [32];
  logic [255:0] rd_pipe [RDL];
  assign mem_dout = rd_pipe[RDL-1];

  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_din;
    rd_pipe[0] <= mem[mem_raddr];
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 256'({mem_we, busy, grant_a, p_rsp_valid, a_rsp_valid,
                               p_req_ready, a_req_ready}), 256'd0);
    check({tag, "_addr"}, 256'({mem_raddr, mem_waddr}), 256'd0);
    check({tag, "_din"}, mem_din, 256'd0);
    check({tag, "_rspd"}, p_rsp_data | a_rsp_data, 256'd0);
`ifdef LC4_DMEM_ARB_STATS_EN
    check({tag, "_stats"}, 256'({stat_p_grants, stat_a_grants, stat_conflicts}), 256'd0);
`endif
  endtask

  // One dre slot in IDLE: check the handshake, the ISSUE cycle, response
  // latency, owner and data, then return to IDLE.
  task automatic slot(input string tag, input bit exp_a, input bit exp_we,
                      input logic [4:0] exp_addr, input logic [255:0] exp_data,
                      input bit drop);
    int  n;
    bit  seen;
    int  exp_lat;
    exp_lat = exp_we ? 2 : RDL + 2;
    dre = 1'b1;
    #1;
    check({tag, "_rdy_p"}, 256'(p_req_ready), 256'(!exp_a));
    check({tag, "_rdy_a"}, 256'(a_req_ready), 256'(exp_a));
    step();
    dre = 1'b0;
    if (drop) begin
      if (exp_a) a_req_valid = 1'b0;
      else       p_req_valid = 1'b0;
    end
    #1;
    check({tag, "_iss_we"}, 256'(mem_we), 256'(exp_we));
    check({tag, "_iss_addr"}, 256'({mem_raddr, mem_waddr}), 256'({exp_addr, exp_addr}));
    check({tag, "_grant"}, 256'({busy, grant_a}), 256'({1'b1, exp_a}));
    n = 1;
    seen = 1'b0;
    while (!seen && n < 20) begin
      step();
      n++;
      seen = exp_a ? a_rsp_valid : p_rsp_valid;
    end
    check({tag, "_lat"}, 256'(n), 256'(exp_lat));
    check({tag, "_data"}, exp_a ? a_rsp_data : p_rsp_data, exp_we ? 256'd0 : exp_data);
    check({tag, "_other"}, 256'({exp_a ? p_rsp_valid : a_rsp_valid, mem_we}), 256'd0);
    step();
    check({tag, "_idle"}, 256'({busy, p_rsp_valid, a_rsp_valid}), 256'd0);
  endtask

  int  n;
  bit  seen;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // Reset: outputs zero, no ready even with dre and a valid request.
    dre = 1'b1;
    p_req_valid = 1'b1;
    #1;
    check_all_zero("rst");
    step();
    step();
    check_all_zero("rst2");
    dre = 1'b0;
    p_req_valid = 1'b0;
    rst = 1'b1;
    step();

    // Both valid at first dre after reset: P first, A next.
    p_req_valid = 1'b1; p_req_we = 1'b1; p_req_addr = 5'h01; p_req_wdata = 256'h11;
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 5'h02; a_req_wdata = 256'h22;
    slot("first_p", 1'b0, 1'b1, 5'h01, 256'h0, 1'b1);
    slot("first_a", 1'b1, 1'b1, 5'h02, 256'h0, 1'b1);

    // Continuous contention for 8 slots: strict alternation P,A,...
    p_req_valid = 1'b1; p_req_we = 1'b0; p_req_addr = 5'h01;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 5'h02;
    for (int i = 0; i < 8; i++) begin
      if (i[0]) slot("alt_a", 1'b1, 1'b0, 5'h02, 256'h22, 1'b0);
      else      slot("alt_p", 1'b0, 1'b0, 5'h01, 256'h11, 1'b0);
    end
    p_req_valid = 1'b0;
    a_req_valid = 1'b0;

    // P write then read-back of the same address.
    p_req_valid = 1'b1; p_req_we = 1'b1; p_req_addr = 5'h03; p_req_wdata = 256'hA5;
    slot("p_wr03", 1'b0, 1'b1, 5'h03, 256'h0, 1'b1);
    p_req_valid = 1'b1; p_req_we = 1'b0; p_req_wdata = 256'h0;
    slot("p_rd03", 1'b0, 1'b0, 5'h03, 256'hA5, 1'b1);

    // dre during RD_WAIT is skipped.
    p_req_valid = 1'b1;
    dre = 1'b1;
    #1;
    check("rw_hs", 256'(p_req_ready), 256'd1);
    step();
    dre = 1'b0;
    p_req_valid = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 5'h1F; a_req_wdata = 256'hBEEF;
    step();
    dre = 1'b1;
    #1;
    check("rw_noready", 256'({p_req_ready, a_req_ready, busy}), 256'b001);
    step();
    dre = 1'b0;
    n = 3;
    while (!p_rsp_valid && n < 20) begin
      step();
      n++;
    end
    check("rw_lat", 256'(n), 256'(RDL + 2));
    check("rw_data", p_rsp_data, 256'hA5);
    step();

    // Valid with dre low for 3 cycles: no ready, no write.
    for (int i = 0; i < 3; i++) begin
      check("nodre", 256'({a_req_ready, p_req_ready, mem_we, busy}), 256'd0);
      step();
    end
    slot("a_wr1f", 1'b1, 1'b1, 5'h1F, 256'h0, 1'b1);

`ifdef LC4_DMEM_ARB_STATS_EN
    check("stat_p", 256'(stat_p_grants), 256'd8);
    check("stat_a", 256'(stat_a_grants), 256'd6);
    check("stat_c", 256'(stat_conflicts), 256'd9);
`endif

    // Reset during RD_WAIT of an A read: transaction dropped.
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 5'h1F;
    dre = 1'b1;
    #1;
    check("rr_hs", 256'(a_req_ready), 256'd1);
    step();
    dre = 1'b0;
    a_req_valid = 1'b0;
    step();
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("rr_async");
    step();
    rst = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      step();
      if (a_rsp_valid || p_rsp_valid || mem_we || busy) seen = 1'b1;
    end
    check("rr_norsp", 256'(seen), 256'd0);
    p_req_valid = 1'b1; p_req_we = 1'b0; p_req_addr = 5'h1F;
    slot("rr_p_rd1f", 1'b0, 1'b0, 5'h1F, 256'hBEEF, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
